// File: rtl/mag_cmp_pkg.sv
// Shared definitions for the mag_cmp sweep checker: FSM state codes and vector-count helpers.
package mag_cmp_pkg;

  localparam int DEF_WIDTH = 2;
  localparam int NVEC      = 1 << (2 * DEF_WIDTH);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_DRIVE  = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_CHECK  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  // Number of (a,b) vectors in a full sweep of a width-bit comparator.
  function automatic int nvec_of(input int width);
    return 1 << (2 * width);
  endfunction

endpackage

// File: rtl/mag_cmp_golden.sv
// Combinational reference magnitude comparator (unsigned) used as the golden model.
module mag_cmp_golden #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/mag_cmp_sweep_checker.sv
// Closed-loop BIST for mag_cmp: sweeps every (a,b) pair, checks the comparator's
// gt/eq/lt against a golden reference and reports error count, first failure and pass/done.
module mag_cmp_sweep_checker
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH      = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [WIDTH-1:0]     cmp_a,
  output logic [WIDTH-1:0]     cmp_b,
  input  logic                 cmp_gt,
  input  logic                 cmp_eq,
  input  logic                 cmp_lt,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH-1:0]     first_fail_a,
  output logic [WIDTH-1:0]     first_fail_b
);

  localparam int EW = 2 * WIDTH + 1;
  localparam int SW = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int NVEC_L = nvec_of(WIDTH);

  localparam logic [WIDTH-1:0] VMAX      = '1;
  localparam logic [EW-1:0]    ESAT      = '1;
  localparam logic [SW-1:0]    SETTLE_LD = SW'(SETTLE_CYC);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [EW-1:0]    err_q, err_d;
  logic [WIDTH-1:0] ffa_q, ffa_d;
  logic [WIDTH-1:0] ffb_q, ffb_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic gold_gt, gold_eq, gold_lt;
  logic mismatch;
  logic last_vec;

  mag_cmp_golden #(
    .WIDTH(WIDTH)
  ) u_golden (
    .a  (a_q),
    .b  (b_q),
    .gt (gold_gt),
    .eq (gold_eq),
    .lt (gold_lt)
  );

  // A not-one-hot response can never equal the one-hot golden value, so one compare covers it.
  assign mismatch = ({cmp_gt, cmp_eq, cmp_lt} != {gold_gt, gold_eq, gold_lt});
  assign last_vec = (a_q == VMAX) && (b_q == VMAX);

  // Next-state, vector stepping and scoreboard update; abort overrides everything else.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffa_d   = ffa_q;
    ffb_d   = ffb_q;
    done_d  = done_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRIVE;
          a_d     = '0;
          b_d     = '0;
          err_d   = '0;
          ffa_d   = '0;
          ffb_d   = '0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        cnt_d   = SETTLE_LD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= SW'(1)) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          if (err_q != ESAT) begin
            err_d = err_q + 1'b1;
          end
          if (err_q == '0) begin
            ffa_d = a_q;
            ffb_d = b_q;
          end
        end
        if (last_vec) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d = ST_DRIVE;
          if (b_q == VMAX) begin
            b_d = '0;
            a_d = a_q + 1'b1;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      err_d   = err_q;
      ffa_d   = ffa_q;
      ffb_d   = ffb_q;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end
  end

  // State and result registers; reset returns everything to zero immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffa_q   <= '0;
      ffb_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffa_q   <= ffa_d;
      ffb_q   <= ffb_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy         = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign cmp_a        = a_q;
  assign cmp_b        = b_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign first_fail_a = ffa_q;
  assign first_fail_b = ffb_q;

  // Elaboration-time sanity: the sweep must fit the error counter without wrapping.
  if (NVEC_L > (1 << EW)) begin : g_bad_width
    $error("error counter too narrow for the sweep");
  end

endmodule

// File: tb/tb_mag_cmp_sweep_checker.sv
// Bench for mag_cmp_sweep_checker: a behavioural comparator (optionally faulty) closes the loop,
// and an abstract sweep model predicts error count, first failure and vector order.
module tb_mag_cmp_sweep_checker;

  localparam int W   = 2;
  localparam int NA  = 1 << W;
  localparam int NV  = NA * NA;
  localparam int PER = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cmp_a, cmp_b;
  logic         cmp_gt, cmp_eq, cmp_lt;
  logic         busy, done, pass;
  logic [2*W:0] err_count;
  logic [W-1:0] first_fail_a, first_fail_b;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  logic [2:0] flip [NV];

  always #5 clk = ~clk;

  mag_cmp_sweep_checker #(
    .WIDTH(W),
    .SETTLE_CYC(1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .cmp_a        (cmp_a),
    .cmp_b        (cmp_b),
    .cmp_gt       (cmp_gt),
    .cmp_eq       (cmp_eq),
    .cmp_lt       (cmp_lt),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .err_count    (err_count),
    .first_fail_a (first_fail_a),
    .first_fail_b (first_fail_b)
  );

  // Comparator under test: 0 good, 1 eq stuck-0, 2 gt/lt swapped, 3 random flips, 4 all outputs 0.
  function automatic logic [2:0] dut_resp(input int m, input int a, input int b);
    logic [2:0] t;
    t = {(a > b), (a == b), (a < b)};
    case (m)
      1: t[1] = 1'b0;
      2: t = {t[0], t[1], t[2]};
      3: t = t ^ flip[a * NA + b];
      4: t = 3'b000;
      default: ;
    endcase
    return t;
  endfunction

  assign {cmp_gt, cmp_eq, cmp_lt} = dut_resp(mode, int'(cmp_a), int'(cmp_b));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected scoreboard after the first nv vectors of a sweep in mode m.
  task automatic model(input int m, input int nv, output int ne, output int fa, output int fb);
    int a, b;
    logic [2:0] truth;
    ne = 0; fa = 0; fb = 0;
    for (int v = 0; v < nv; v++) begin
      a = v / NA;
      b = v % NA;
      truth = {(a > b), (a == b), (a < b)};
      if (dut_resp(m, a, b) != truth) begin
        if (ne == 0) begin
          fa = a;
          fb = b;
        end
        if (ne < 31) ne++;
      end
    end
  endtask

  task automatic sweep(input int m, input bit extra_start);
    int k, ne, fa, fb;
    mode = m;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("err_cleared_on_start", int'(err_count), 0);
    chk("done_cleared_on_start", int'(done), 0);
    k = 0;
    while (busy && k < 200) begin
      if (k % PER == 0) chk("vector_order", int'({cmp_a, cmp_b}), k / PER);
      start = extra_start && (k == 10);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk("busy_cycles", k, NV * PER);
    model(m, NV, ne, fa, fb);
    chk("done", int'(done), 1);
    chk("pass", int'(pass), int'(ne == 0));
    chk("err_count", int'(err_count), ne);
    if (ne != 0) begin
      chk("first_fail_a", int'(first_fail_a), fa);
      chk("first_fail_b", int'(first_fail_b), fb);
    end
    if (extra_start) begin
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start_in_done_ignored", int'(busy), 0);
      chk("done_persists", int'(done), 1);
      @(negedge clk);
      chk("still_idle", int'(busy), 0);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_err"}, int'(err_count), 0);
    chk({tag, "_ff"}, int'({first_fail_a, first_fail_b}), 0);
    chk({tag, "_cmp"}, int'({cmp_a, cmp_b}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ne, fa, fb;
    for (int i = 0; i < NV; i++) flip[i] = 3'($urandom_range(0, 7));

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    sweep(0, 1'b0);
    sweep(1, 1'b0);
    sweep(2, 1'b0);
    sweep(4, 1'b0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NV; i++) flip[i] = 3'($urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      sweep(3, 1'b0);
    end

    // Abort during the sweep: vectors 0..5 have been checked when abort lands on cycle 20.
    for (int i = 0; i < NV; i++) flip[i] = 3'($urandom_range(1, 7));
    mode = 3;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    model(3, 6, ne, fa, fb);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_cmp", int'({cmp_a, cmp_b}), 0);
    chk("abort_err_kept", int'(err_count), ne);
    chk("abort_ff_kept", int'({first_fail_a, first_fail_b}), fa * NA + fb);
    sweep(0, 1'b0);

    // Reset in the middle of a sweep, then a clean full sweep.
    mode = 2;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk); rst_n = 1'b1;
    sweep(0, 1'b0);

    // Start pulses while busy and in the DONE cycle must be ignored.
    sweep(0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
